ex_stage_pipe: RTL and testbench



---
 rtl/cpu_pkg.sv | 79 +++++++
 rtl/alu.sv | 67 ++++++
 rtl/ex_stage_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, forwarding-select encodings and EX pipeline payloads.
// Imported by the decoder and by ex_stage_pipe.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned FWD_W  = 2;

    typedef logic [OP_W-1:0]  alu_op_t;
    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam alu_op_t ALU_ADD   = 5'd0;
    localparam alu_op_t ALU_ADDU  = 5'd1;
    localparam alu_op_t ALU_SUB   = 5'd2;
    localparam alu_op_t ALU_SUBU  = 5'd3;
    localparam alu_op_t ALU_AND   = 5'd4;
    localparam alu_op_t ALU_NOR   = 5'd5;
    localparam alu_op_t ALU_OR    = 5'd6;
    localparam alu_op_t ALU_XOR   = 5'd7;
    localparam alu_op_t ALU_SLL   = 5'd8;
    localparam alu_op_t ALU_SLLV  = 5'd9;
    localparam alu_op_t ALU_SRL   = 5'd10;
    localparam alu_op_t ALU_SRLV  = 5'd11;
    localparam alu_op_t ALU_SRA   = 5'd12;
    localparam alu_op_t ALU_SRAV  = 5'd13;
    localparam alu_op_t ALU_SLT   = 5'd14;
    localparam alu_op_t ALU_JR    = 5'd15;
    localparam alu_op_t ALU_ADDI  = 5'd16;
    localparam alu_op_t ALU_ADDIU = 5'd17;
    localparam alu_op_t ALU_ANDI  = 5'd18;
    localparam alu_op_t ALU_ORI   = 5'd19;
    localparam alu_op_t ALU_BEQ   = 5'd20;
    localparam alu_op_t ALU_BNE   = 5'd21;
    localparam alu_op_t ALU_LW    = 5'd22;
    localparam alu_op_t ALU_SW    = 5'd23;
    localparam alu_op_t ALU_J     = 5'd24;
    localparam alu_op_t ALU_JAL   = 5'd25;
    localparam alu_op_t ALU_XORI  = 5'd26;

    localparam fwd_sel_t FWD_IDEX     = 2'b00;
    localparam fwd_sel_t FWD_MEM      = 2'b01;
    localparam fwd_sel_t FWD_WB       = 2'b10;
    localparam fwd_sel_t FWD_IDEX_ALT = 2'b11;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              mem_read;
        logic              alu_src;
        logic              reg_dst;
        logic              sig_shamp;
        logic              I_type;
        logic              sw;
        alu_op_t           alu_control;
        logic [DATA_W-1:0] extend_num;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [REG_W-1:0]  rs_address;
        logic [REG_W-1:0]  rt_address;
        logic [REG_W-1:0]  rd_address;
        logic [REG_W-1:0]  shamp;
    } id_ex_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              mem_read;
        logic              I_type;
        logic              sw;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
        logic [REG_W-1:0]  rd_address;
    } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational execute-stage ALU; result plus {zero, negative, overflow} flags.
// Flag outputs exist only when EX_FLAGS_EN is defined.
module alu
    import cpu_pkg::*;
(
    input  alu_op_t           alu_control,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result
`ifdef EX_FLAGS_EN
    ,
    output logic [2:0]        flags
`endif
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD, ALU_ADDU, ALU_ADDI, ALU_ADDIU, ALU_LW, ALU_SW:
                result = src_a + src_b;
            ALU_SUB, ALU_SUBU, ALU_BEQ, ALU_BNE:
                result = src_a - src_b;
            ALU_AND, ALU_ANDI:
                result = src_a & src_b;
            ALU_NOR:
                result = ~(src_a | src_b);
            ALU_OR, ALU_ORI:
                result = src_a | src_b;
            ALU_XOR, ALU_XORI:
                result = src_a ^ src_b;
            ALU_SLL, ALU_SLLV:
                result = src_b << src_a[4:0];
            ALU_SRL, ALU_SRLV:
                result = src_b >> src_a[4:0];
            ALU_SRA, ALU_SRAV:
                result = DATA_W'($signed(src_b) >>> src_a[4:0]);
            ALU_SLT:
                result = DATA_W'($signed(src_a) < $signed(src_b));
            ALU_JR, ALU_J, ALU_JAL:
                result = '0;
            default:
                result = '0;
        endcase
    end

`ifdef EX_FLAGS_EN
    logic overflow;

    // Signed overflow is reported only for the trapping-class ops, never acted on here.
    always_comb begin
        overflow = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_ADDI:
                overflow = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                           (result[DATA_W-1] != src_a[DATA_W-1]);
            ALU_SUB:
                overflow = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                           (result[DATA_W-1] != src_a[DATA_W-1]);
            default:
                overflow = 1'b0;
        endcase
    end

    assign flags = {(result == '0), result[DATA_W-1], overflow};
`endif

endmodule

// File: rtl/ex_stage_pipe.sv
// MIPS execute-stage slice: ID/EX register, forwarding/operand muxes, ALU, EX/MEM register.
// Define EX_FLAGS_EN to compute ALU flags and register them as flags_m.
module ex_stage_pipe
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sig_stall,
    input  logic        reg_write_d,
    input  logic        mem_to_reg_d,
    input  logic        mem_write_d,
    input  logic        mem_read_d,
    input  logic        alu_src_d,
    input  logic        reg_dst_d,
    input  logic        sig_shamp_d,
    input  logic        I_type_d,
    input  logic        sw_d,
    input  logic [4:0]  alu_control_d,
    input  logic [31:0] extend_num_d,
    input  logic [31:0] rs_data_d,
    input  logic [31:0] rt_data_d,
    input  logic [4:0]  rs_address_d,
    input  logic [4:0]  rt_address_d,
    input  logic [4:0]  rd_address_d,
    input  logic [4:0]  shamp_d,
    input  logic [1:0]  fwd_sel_a,
    input  logic [1:0]  fwd_sel_b,
    input  logic [31:0] result_w,
    output logic [4:0]  rs_address_e,
    output logic [4:0]  rt_address_e,
    output logic        mem_read_e,
    output logic        I_type_e,
    output logic        sw_e,
    output logic [2:0]  flags,
    output logic        reg_write_m,
    output logic        mem_to_reg_m,
    output logic        mem_write_m,
    output logic        mem_read_m,
    output logic        I_type_m,
    output logic        sw_m,
    output logic [31:0] alu_out_m,
    output logic [31:0] write_data_m,
    output logic [4:0]  write_reg_m,
    output logic [4:0]  rd_address_m
`ifdef EX_FLAGS_EN
    ,
    output logic [2:0]  flags_m
`endif
);

    id_ex_t            id_ex_d, id_ex_q;
    ex_mem_t           ex_mem_d, ex_mem_q;
    logic [DATA_W-1:0] fwd_a, fwd_b, src_a, src_b, alu_result;
    logic [REG_W-1:0]  write_reg_e;

    always_comb begin
        id_ex_d             = '0;
        id_ex_d.reg_write   = reg_write_d;
        id_ex_d.mem_to_reg  = mem_to_reg_d;
        id_ex_d.mem_write   = mem_write_d;
        id_ex_d.mem_read    = mem_read_d;
        id_ex_d.alu_src     = alu_src_d;
        id_ex_d.reg_dst     = reg_dst_d;
        id_ex_d.sig_shamp   = sig_shamp_d;
        id_ex_d.I_type      = I_type_d;
        id_ex_d.sw          = sw_d;
        id_ex_d.alu_control = alu_control_d;
        id_ex_d.extend_num  = extend_num_d;
        id_ex_d.rs_data     = rs_data_d;
        id_ex_d.rt_data     = rt_data_d;
        id_ex_d.rs_address  = rs_address_d;
        id_ex_d.rt_address  = rt_address_d;
        id_ex_d.rd_address  = rd_address_d;
        id_ex_d.shamp       = shamp_d;
    end

    // A stall loads an all-zero bubble; the upstream stage re-presents its instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else if (sig_stall) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // MEM forwarding uses the registered EX/MEM result, so no combinational loop forms.
    always_comb begin
        fwd_a = id_ex_q.rs_data;
        case (fwd_sel_a)
            FWD_MEM:            fwd_a = ex_mem_q.alu_out;
            FWD_WB:             fwd_a = result_w;
            FWD_IDEX, FWD_IDEX_ALT: fwd_a = id_ex_q.rs_data;
            default:            fwd_a = id_ex_q.rs_data;
        endcase
    end

    always_comb begin
        fwd_b = id_ex_q.rt_data;
        case (fwd_sel_b)
            FWD_MEM:            fwd_b = ex_mem_q.alu_out;
            FWD_WB:             fwd_b = result_w;
            FWD_IDEX, FWD_IDEX_ALT: fwd_b = id_ex_q.rt_data;
            default:            fwd_b = id_ex_q.rt_data;
        endcase
    end

    assign src_a       = id_ex_q.sig_shamp ? DATA_W'(id_ex_q.shamp) : fwd_a;
    assign src_b       = id_ex_q.alu_src ? id_ex_q.extend_num : fwd_b;
    assign write_reg_e = id_ex_q.reg_dst ? id_ex_q.rd_address : id_ex_q.rt_address;

`ifdef EX_FLAGS_EN
    logic [2:0] flags_q;

    alu u_alu (
        .alu_control (id_ex_q.alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (alu_result),
        .flags       (flags)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags;
        end
    end

    assign flags_m = flags_q;
`else
    alu u_alu (
        .alu_control (id_ex_q.alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (alu_result)
    );

    assign flags = 3'b000;
`endif

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.I_type     = id_ex_q.I_type;
        ex_mem_d.sw         = id_ex_q.sw;
        ex_mem_d.alu_out    = alu_result;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.write_reg  = write_reg_e;
        ex_mem_d.rd_address = id_ex_q.rd_address;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign rs_address_e = id_ex_q.rs_address;
    assign rt_address_e = id_ex_q.rt_address;
    assign mem_read_e   = id_ex_q.mem_read;
    assign I_type_e     = id_ex_q.I_type;
    assign sw_e         = id_ex_q.sw;

    assign reg_write_m  = ex_mem_q.reg_write;
    assign mem_to_reg_m = ex_mem_q.mem_to_reg;
    assign mem_write_m  = ex_mem_q.mem_write;
    assign mem_read_m   = ex_mem_q.mem_read;
    assign I_type_m     = ex_mem_q.I_type;
    assign sw_m         = ex_mem_q.sw;
    assign alu_out_m    = ex_mem_q.alu_out;
    assign write_data_m = ex_mem_q.write_data;
    assign write_reg_m  = ex_mem_q.write_reg;
    assign rd_address_m = ex_mem_q.rd_address;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe; flag checks follow EX_FLAGS_EN.
module tb_ex_stage_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        sig_stall;
    logic        reg_write_d, mem_to_reg_d, mem_write_d, mem_read_d, alu_src_d;
    logic        reg_dst_d, sig_shamp_d, I_type_d, sw_d;
    logic [4:0]  alu_control_d;
    logic [31:0] extend_num_d, rs_data_d, rt_data_d;
    logic [4:0]  rs_address_d, rt_address_d, rd_address_d, shamp_d;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [31:0] result_w;
    logic [4:0]  rs_address_e, rt_address_e;
    logic        mem_read_e, I_type_e, sw_e;
    logic [2:0]  flags;
    logic        reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m, I_type_m, sw_m;
    logic [31:0] alu_out_m, write_data_m;
    logic [4:0]  write_reg_m, rd_address_m;
`ifdef EX_FLAGS_EN
    logic [2:0]  flags_m;
`endif

    int checks = 0;
    int errors = 0;

    ex_stage_pipe dut (
        .clock        (clock),
        .reset        (reset),
        .sig_stall    (sig_stall),
        .reg_write_d  (reg_write_d),
        .mem_to_reg_d (mem_to_reg_d),
        .mem_write_d  (mem_write_d),
        .mem_read_d   (mem_read_d),
        .alu_src_d    (alu_src_d),
        .reg_dst_d    (reg_dst_d),
        .sig_shamp_d  (sig_shamp_d),
        .I_type_d     (I_type_d),
        .sw_d         (sw_d),
        .alu_control_d(alu_control_d),
        .extend_num_d (extend_num_d),
        .rs_data_d    (rs_data_d),
        .rt_data_d    (rt_data_d),
        .rs_address_d (rs_address_d),
        .rt_address_d (rt_address_d),
        .rd_address_d (rd_address_d),
        .shamp_d      (shamp_d),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .result_w     (result_w),
        .rs_address_e (rs_address_e),
        .rt_address_e (rt_address_e),
        .mem_read_e   (mem_read_e),
        .I_type_e     (I_type_e),
        .sw_e         (sw_e),
        .flags        (flags),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .mem_write_m  (mem_write_m),
        .mem_read_m   (mem_read_m),
        .I_type_m     (I_type_m),
        .sw_m         (sw_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m),
        .rd_address_m (rd_address_m)
`ifdef EX_FLAGS_EN
        ,
        .flags_m      (flags_m)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags read zero when the flag logic is not built.
    function automatic logic [2:0] ef(input logic [2:0] f);
`ifdef EX_FLAGS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_d();
        sig_stall = 0;
        reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0; mem_read_d = 0;
        alu_src_d = 0; reg_dst_d = 0; sig_shamp_d = 0; I_type_d = 0; sw_d = 0;
        alu_control_d = 5'd0; extend_num_d = 0; rs_data_d = 0; rt_data_d = 0;
        rs_address_d = 0; rt_address_d = 0; rd_address_d = 0; shamp_d = 0;
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00; result_w = 0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt);
        clear_d();
        alu_control_d = op; rs_data_d = rs; rt_data_d = rt; reg_write_d = 1;
    endtask

    initial begin
        reset = 1;
        clear_d();
        step();
        step();
        chk("reset_alu_out_m", alu_out_m, 32'h0);
        chk("reset_reg_write_m", 32'(reg_write_m), 32'h0);
        chk("reset_flags", 32'(flags), 32'(ef(3'b100)));
        reset = 0;

        // ADD overflow, then ADDU on the same operands
        issue(5'd0, 32'h7FFF_FFFF, 32'h1);
        reg_dst_d = 1; rd_address_d = 5'd3; rs_address_d = 5'd8; rt_address_d = 5'd9;
        step();
        chk("add_rs_address_e", 32'(rs_address_e), 32'd8);
        chk("add_rt_address_e", 32'(rt_address_e), 32'd9);
        chk("add_flags", 32'(flags), 32'(ef(3'b011)));
        issue(5'd1, 32'h7FFF_FFFF, 32'h1);
        step();
        chk("add_alu_out_m", alu_out_m, 32'h8000_0000);
        chk("add_write_reg_m", 32'(write_reg_m), 32'd3);
        chk("add_reg_write_m", 32'(reg_write_m), 32'd1);
        chk("addu_flags", 32'(flags), 32'(ef(3'b010)));
`ifdef EX_FLAGS_EN
        chk("add_flags_m", 32'(flags_m), 32'b011);
`endif
        clear_d();
        step();
        chk("addu_alu_out_m", alu_out_m, 32'h8000_0000);

        // Shifts by shamp, then SLLV using only rs[4:0]
        issue(5'd12, 32'h0, 32'hF000_0000);
        sig_shamp_d = 1; shamp_d = 5'd4;
        step();
        issue(5'd10, 32'h0, 32'hF000_0000);
        sig_shamp_d = 1; shamp_d = 5'd4;
        step();
        chk("sra_alu_out_m", alu_out_m, 32'hFF00_0000);
        issue(5'd9, 32'd33, 32'd1);
        step();
        chk("srl_alu_out_m", alu_out_m, 32'h0F00_0000);
        issue(5'd14, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("sllv_alu_out_m", alu_out_m, 32'd2);
        clear_d();
        step();
        chk("slt_alu_out_m", alu_out_m, 32'd1);

        // Store with negative immediate
        clear_d();
        alu_control_d = 5'd23; alu_src_d = 1; extend_num_d = 32'hFFFF_FFFC;
        rs_data_d = 32'h100; rt_data_d = 32'hDEAD_BEEF; mem_write_d = 1; sw_d = 1; I_type_d = 1;
        step();
        chk("sw_sw_e", 32'(sw_e), 32'd1);
        chk("sw_I_type_e", 32'(I_type_e), 32'd1);
        chk("sw_flags", 32'(flags), 32'(ef(3'b000)));
        clear_d();
        step();
        chk("sw_alu_out_m", alu_out_m, 32'h0000_00FC);
        chk("sw_write_data_m", write_data_m, 32'hDEAD_BEEF);
        chk("sw_mem_write_m", 32'(mem_write_m), 32'd1);
        chk("sw_sw_m", 32'(sw_m), 32'd1);

        // Load followed by a one-cycle stall bubble
        clear_d();
        alu_control_d = 5'd22; alu_src_d = 1; extend_num_d = 32'd4; rs_data_d = 32'h10;
        reg_write_d = 1; mem_read_d = 1; mem_to_reg_d = 1;
        step();
        chk("lw_mem_read_e", 32'(mem_read_e), 32'd1);
        sig_stall = 1;
        step();
        chk("stall_mem_read_e", 32'(mem_read_e), 32'd0);
        chk("stall_flags", 32'(flags), 32'(ef(3'b100)));
        chk("lw_mem_read_m", 32'(mem_read_m), 32'd1);
        chk("lw_mem_to_reg_m", 32'(mem_to_reg_m), 32'd1);
        chk("lw_alu_out_m", alu_out_m, 32'h14);
        clear_d();
        step();
        chk("bubble_reg_write_m", 32'(reg_write_m), 32'd0);
        chk("bubble_mem_write_m", 32'(mem_write_m), 32'd0);
        chk("bubble_mem_read_m", 32'(mem_read_m), 32'd0);

        // Forwarding from MEM (3+4=7, then 7+5=12) and from WB
        issue(5'd0, 32'd3, 32'd4);
        step();
        issue(5'd0, 32'd99, 32'd5);
        step();
        clear_d();
        fwd_sel_a = 2'b01;
        step();
        chk("fwd_mem_alu_out_m", alu_out_m, 32'd12);
        issue(5'd0, 32'd1, 32'd100);
        step();
        clear_d();
        fwd_sel_b = 2'b10; result_w = 32'd9;
        step();
        chk("fwd_wb_alu_out_m", alu_out_m, 32'd10);
        chk("fwd_wb_write_data_m", write_data_m, 32'd9);
        issue(5'd2, 32'd50, 32'd8);
        step();
        fwd_sel_a = 2'b11; fwd_sel_b = 2'b11;
        step();
        chk("fwd_alt_alu_out_m", alu_out_m, 32'd42);

        // Reset mid-stream clears both stages without a clock edge
        issue(5'd6, 32'h5, 32'hA);
        rs_address_d = 5'd7; mem_read_d = 1;
        step();
        issue(5'd6, 32'h1, 32'h2);
        rs_address_d = 5'd7; mem_read_d = 1;
        step();
        chk("pre_reset_alu_out_m", alu_out_m, 32'hF);
        clear_d();
        reset = 1;
        #1;
        chk("mid_reset_alu_out_m", alu_out_m, 32'h0);
        chk("mid_reset_reg_write_m", 32'(reg_write_m), 32'd0);
        chk("mid_reset_rs_address_e", 32'(rs_address_e), 32'd0);
        chk("mid_reset_mem_read_e", 32'(mem_read_e), 32'd0);
        chk("mid_reset_flags", 32'(flags), 32'(ef(3'b100)));
        step();
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
